// File: rtl/mem_port_arbiter.sv
// Merges line read/write traffic from NUM_CH cache channels onto one memory port,
// serving a single transaction at a time with round-robin or fixed-priority grant.
module mem_port_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 28,
  parameter int LINE_W  = 128,
  parameter int RR_MODE = 1,
  localparam int GID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_ready,
  output logic [GID_W-1:0]         grant_id
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg;
  logic [GID_W-1:0]  rr_ptr_reg;
  logic [ADDR_W-1:0] addr_arr  [NUM_CH];
  logic [LINE_W-1:0] wdata_arr [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic [GID_W-1:0]  search_base;
  logic [GID_W-1:0]  win;
  logic [GID_W-1:0]  next_ptr;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign addr_arr[gi]  = ch_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = ch_wdata[gi*LINE_W +: LINE_W];
    end
  endgenerate

  assign req         = ch_read | ch_write;
  assign search_base = (RR_MODE != 0) ? rr_ptr_reg : '0;
  assign next_ptr    = (grant_id == GID_W'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;

  // Scan upward from the base index with wrap; the first requester wins.
  always_comb begin
    logic             found;
    logic [GID_W-1:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = GID_W'((int'(search_base) + k) % NUM_CH);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      grant_id   <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ch_ready   <= '0;
      ch_rdata   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req != '0) begin
            mem_addr  <= addr_arr[win];
            mem_wdata <= wdata_arr[win];
            // A simultaneous read and write from one channel becomes a write.
            mem_write <= ch_write[win];
            mem_read  <= ch_read[win] & ~ch_write[win];
            grant_id  <= win;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            ch_rdata  <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ch_ready  <= NUM_CH'(1) << grant_id;
            state_reg <= DONE;
          end
        end
        DONE: begin
          // No grant here, so the finished channel's still-held request is not re-served.
          ch_ready  <= '0;
          if (RR_MODE != 0) rr_ptr_reg <= next_ptr;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter from shared stimulus; both run
// in lockstep, and each has its own queue of expected grants.
module tb_mem_port_arbiter;

  localparam int NCH = 2;
  localparam int AW  = 28;
  localparam int LW  = 128;

  logic            clk;
  logic            rst_n;
  logic [NCH-1:0]  ch_read, ch_write;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*LW-1:0] ch_wdata;
  logic [LW-1:0]   mem_rdata;
  logic            mem_ready;

  logic [LW-1:0]   rr_rdata, fp_rdata;
  logic [NCH-1:0]  rr_ready, fp_ready;
  logic            rr_mem_read, rr_mem_write, fp_mem_read, fp_mem_write;
  logic [AW-1:0]   rr_mem_addr, fp_mem_addr;
  logic [LW-1:0]   rr_mem_wdata, fp_mem_wdata;
  logic            rr_gid, fp_gid;

  mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .ch_read(ch_read), .ch_write(ch_write),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rdata(rr_rdata), .ch_ready(rr_ready),
    .mem_read(rr_mem_read), .mem_write(rr_mem_write), .mem_addr(rr_mem_addr),
    .mem_wdata(rr_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_id(rr_gid)
  );

  mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .ch_read(ch_read), .ch_write(ch_write),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rdata(fp_rdata), .ch_ready(fp_ready),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_id(fp_gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic       rd;
    logic       wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } exp_t;

  typedef struct {
    logic [NCH-1:0] rd;
    logic [NCH-1:0] wr;
    int             lat;
    logic [LW-1:0]  rdata;
    int             rr_ch;
    logic           rr_rd;
    logic           rr_wr;
    int             fp_ch;
    logic           fp_rd;
    logic           fp_wr;
  } vec_t;

  exp_t q_rr[$];
  exp_t q_fp[$];
  logic [AW-1:0] addr_c [NCH];
  logic [LW-1:0] wdata_c [NCH];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_defaults();
    ch_addr  = {addr_c[1], addr_c[0]};
    ch_wdata = {wdata_c[1], wdata_c[0]};
  endtask

  task automatic expect_grant(input int rch, input logic rrd, input logic rwr,
                              input int fch, input logic frd, input logic fwr);
    exp_t e;
    e.ch = rch; e.rd = rrd; e.wr = rwr; e.addr = addr_c[rch]; e.wdata = wdata_c[rch];
    q_rr.push_back(e);
    e.ch = fch; e.rd = frd; e.wr = fwr; e.addr = addr_c[fch]; e.wdata = wdata_c[fch];
    q_fp.push_back(e);
  endtask

  // Wait for a grant, check it against the scoreboard, answer it, check completion.
  task automatic serve(input int lat, input logic [LW-1:0] rd, input logic [NCH-1:0] drop,
                       input bit perturb, input int exp_wait);
    exp_t er, ef;
    logic [NCH-1:0] oh_r, oh_f;
    int n;
    n = 0;
    while (!(rr_mem_read || rr_mem_write) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: no memory strobe within %0d cycles", n);
      return;
    end
    if (exp_wait >= 0) chk("grant_latency", LW'(n), LW'(exp_wait));
    if (q_rr.size() == 0 || q_fp.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: grant seen with no expected entry");
      return;
    end
    er = q_rr.pop_front();
    ef = q_fp.pop_front();
    chk("rr_grant_id", LW'(rr_gid), LW'(er.ch));
    chk("rr_mem_addr", LW'(rr_mem_addr), LW'(er.addr));
    chk("rr_mem_read", LW'(rr_mem_read), LW'(er.rd));
    chk("rr_mem_write", LW'(rr_mem_write), LW'(er.wr));
    chk("rr_mem_wdata", rr_mem_wdata, er.wdata);
    chk("fp_grant_id", LW'(fp_gid), LW'(ef.ch));
    chk("fp_mem_addr", LW'(fp_mem_addr), LW'(ef.addr));
    chk("fp_mem_read", LW'(fp_mem_read), LW'(ef.rd));
    chk("fp_mem_write", LW'(fp_mem_write), LW'(ef.wr));
    if (perturb) begin
      ch_addr  = '1;
      ch_wdata = '1;
    end
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("rr_addr_hold", LW'(rr_mem_addr), LW'(er.addr));
      chk("rr_strobe_hold", LW'({rr_mem_read, rr_mem_write}), LW'({er.rd, er.wr}));
      if (perturb) chk("rr_wdata_hold", rr_mem_wdata, er.wdata);
    end
    mem_rdata = rd;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    oh_r = NCH'(1) << er.ch;
    oh_f = NCH'(1) << ef.ch;
    chk("rr_ch_ready", LW'(rr_ready), LW'(oh_r));
    chk("rr_ch_rdata", rr_rdata, rd);
    chk("rr_strobe_drop", LW'({rr_mem_read, rr_mem_write}), '0);
    chk("fp_ch_ready", LW'(fp_ready), LW'(oh_f));
    chk("fp_ch_rdata", fp_rdata, rd);
    ch_read  = ch_read & ~drop;
    ch_write = ch_write & ~drop;
    if (perturb) drive_defaults();
    $display("txn rr_ch=%0d fp_ch=%0d rdata=%0h wait=%0d", er.ch, ef.ch, rd, n);
    tick();
    chk("rr_ready_pulse", LW'(rr_ready), '0);
    chk("fp_ready_pulse", LW'(fp_ready), '0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  vec_t vecs [7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_c[0]  = 28'h0000010;
    addr_c[1]  = 28'h0000020;
    wdata_c[0] = 128'h1111;
    wdata_c[1] = 128'hDEAD;

    //          rd     wr     lat rdata      rr: ch rd wr   fp: ch rd wr
    vecs[0] = '{2'b01, 2'b00, 5, 128'hA5,   0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
    vecs[1] = '{2'b11, 2'b00, 2, 128'hB6,   1, 1'b1, 1'b0, 0, 1'b1, 1'b0};
    vecs[2] = '{2'b11, 2'b10, 1, 128'hC7,   0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
    vecs[3] = '{2'b10, 2'b10, 3, 128'hD8,   1, 1'b0, 1'b1, 1, 1'b0, 1'b1};
    vecs[4] = '{2'b00, 2'b01, 0, 128'hE9,   0, 1'b0, 1'b1, 0, 1'b0, 1'b1};
    vecs[5] = '{2'b01, 2'b10, 2, 128'hFA,   1, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[6] = '{2'b11, 2'b00, 1, 128'h0B,   0, 1'b1, 1'b0, 0, 1'b1, 1'b0};

    ch_read = '0; ch_write = '0; mem_rdata = '0; mem_ready = 1'b0;
    drive_defaults();
    rst_n = 1'b0;
    tick();
    chk("rst_mem_read", LW'(rr_mem_read), '0);
    chk("rst_mem_write", LW'(rr_mem_write), '0);
    chk("rst_mem_addr", LW'(rr_mem_addr), '0);
    chk("rst_mem_wdata", rr_mem_wdata, '0);
    chk("rst_ch_ready", LW'(rr_ready), '0);
    chk("rst_ch_rdata", rr_rdata, '0);
    chk("rst_grant_id", LW'(rr_gid), '0);
    chk("rst_fp_ready", LW'(fp_ready), '0);
    rst_n = 1'b1;
    tick();

    // mem_ready in IDLE must be ignored.
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("idle_mem_ready_ignored", LW'(rr_ready), '0);
    chk("idle_no_strobe", LW'({rr_mem_read, rr_mem_write}), '0);

    foreach (vecs[i]) begin
      ch_read  = vecs[i].rd;
      ch_write = vecs[i].wr;
      expect_grant(vecs[i].rr_ch, vecs[i].rr_rd, vecs[i].rr_wr,
                   vecs[i].fp_ch, vecs[i].fp_rd, vecs[i].fp_wr);
      serve(vecs[i].lat, vecs[i].rdata, 2'b11, 1'b0, 1);
    end

    // Continuous requests from both channels after reset.
    apply_reset();
    ch_read = 2'b11;
    for (int i = 0; i < 4; i++) expect_grant(i % 2, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) serve(1, LW'(128'h100 + i), (i == 3) ? 2'b11 : 2'b00, 1'b0, 1);

    // ch1 holds its request; ch0 arrives once and is served next.
    ch_read = 2'b10;
    expect_grant(1, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    serve(2, 128'h201, 2'b00, 1'b0, 1);
    ch_read = 2'b11;
    expect_grant(0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    serve(2, 128'h202, 2'b01, 1'b0, 1);
    expect_grant(1, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    serve(2, 128'h203, 2'b11, 1'b0, 1);

    // Channel inputs change while BUSY; latched values must hold.
    ch_read = 2'b01;
    expect_grant(0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    serve(4, 128'h77, 2'b11, 1'b1, 1);

    // Reset two cycles into a read.
    ch_read = 2'b10;
    tick();
    chk("pre_rst_grant_id", LW'(rr_gid), LW'(1));
    chk("pre_rst_mem_read", LW'(rr_mem_read), LW'(1));
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_read", LW'(rr_mem_read), '0);
    chk("async_rst_grant_id", LW'(rr_gid), '0);
    chk("async_rst_ch_ready", LW'(rr_ready), '0);
    chk("async_rst_mem_addr", LW'(rr_mem_addr), '0);
    chk("async_rst_fp_gid", LW'(fp_gid), '0);
    ch_read = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_strobes", LW'({rr_mem_read, rr_mem_write}), '0);
    chk("post_rst_ready", LW'(rr_ready), '0);
    chk("post_rst_gid", LW'(rr_gid), '0);
    chk("post_rst_rdata", rr_rdata, '0);
    chk("scoreboard_drained", LW'(q_rr.size() + q_fp.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
